// File: rtl/fpnew_pkg.sv
// Shared constants and types for the cast-unit request arbiter.
package fpnew_pkg;

    localparam int unsigned MaxNumReq        = 8;
    localparam int unsigned MaxInFlightLimit = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } cast_arb_state_e;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpnew_cast_arbiter_if.sv
// Requester-side and cast-pipeline-side handshakes of the cast arbiter.
interface fpnew_cast_arbiter_if
    import fpnew_pkg::*;
#(
    parameter int unsigned NumReq      = 2,
    parameter type         PayloadType = logic
);
    localparam int unsigned IdWidth = id_width(NumReq);

    logic [NumReq-1:0]  req_valid_i;
    logic [NumReq-1:0]  req_ready_o;
    PayloadType         req_data_i [NumReq];
    logic               unit_valid_o;
    logic               unit_ready_i;
    PayloadType         unit_data_o;
    logic [IdWidth-1:0] unit_id_o;
    logic               unit_out_valid_i;
    logic [IdWidth-1:0] unit_out_id_i;
    logic               unit_out_ready_o;
    logic [NumReq-1:0]  resp_valid_o;
    logic [NumReq-1:0]  resp_ready_i;

    modport master (
        input  req_valid_i, req_data_i, unit_ready_i,
        input  unit_out_valid_i, unit_out_id_i, resp_ready_i,
        output req_ready_o, unit_valid_o, unit_data_o, unit_id_o,
        output unit_out_ready_o, resp_valid_o
    );

    modport slave (
        output req_valid_i, req_data_i, unit_ready_i,
        output unit_out_valid_i, unit_out_id_i, resp_ready_i,
        input  req_ready_o, unit_valid_o, unit_data_o, unit_id_o,
        input  unit_out_ready_o, resp_valid_o
    );

endinterface

// File: rtl/fpnew_cast_arbiter_rr_pick.sv
// Cyclic priority search: first valid requester at or after ptr.
module fpnew_cast_arbiter_rr_pick #(
    parameter int unsigned NumReq  = 2,
    parameter int unsigned IdWidth = 1
) (
    input  logic [NumReq-1:0]  valid,
    input  logic [IdWidth-1:0] ptr,
    output logic               gnt_valid,
    output logic [IdWidth-1:0] gnt_idx
);

    always_comb begin
        int unsigned k;
        k         = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            k = 32'(ptr) + i;
            if (k >= NumReq) k = k - NumReq;
            if (!gnt_valid && valid[k[IdWidth-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = k[IdWidth-1:0];
            end
        end
    end

endmodule

// File: rtl/fpnew_cast_arbiter.sv
// Round-robin arbiter sharing one cast pipeline among NumReq requesters,
// with in-flight credit counting and zero-latency tag-based result routing.
module fpnew_cast_arbiter
    import fpnew_pkg::*;
#(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned MaxInFlight = 4,
    parameter type         PayloadType = logic
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    fpnew_cast_arbiter_if.master  bus
);

    localparam int unsigned IdWidth  = id_width(NumReq);
    localparam int unsigned CntWidth = $clog2(MaxInFlight + 1);

    cast_arb_state_e     state_q;
    logic [IdWidth-1:0]  rr_ptr_q;
    logic [IdWidth-1:0]  grant_q;
    logic [CntWidth-1:0] count_q;

    logic               pick_valid;
    logic [IdWidth-1:0] pick_idx;
    logic [IdWidth-1:0] issue_idx;
    logic [IdWidth-1:0] next_ptr;
    logic               credit;
    logic               unit_valid;
    logic               issue_hs;
    logic               result_hs;
    logic               count_dec;
    logic               route_ok;
    PayloadType         issue_data;

    fpnew_cast_arbiter_rr_pick #(
        .NumReq  (NumReq),
        .IdWidth (IdWidth)
    ) u_rr_pick (
        .valid     (bus.req_valid_i),
        .ptr       (rr_ptr_q),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    // A pending offer keeps its latched lane; otherwise the picker decides.
    assign issue_idx  = (state_q == OFFER) ? grant_q : pick_idx;
    assign issue_data = bus.req_data_i[issue_idx];
    assign credit     = count_q < CntWidth'(MaxInFlight);
    assign unit_valid = !rst_i && !flush_i && credit
                        && ((state_q == OFFER) || pick_valid);
    assign issue_hs   = unit_valid && bus.unit_ready_i;
    assign next_ptr   = (32'(issue_idx) == NumReq - 1) ? '0 : issue_idx + IdWidth'(1);

    assign route_ok   = 32'(bus.unit_out_id_i) < 32'(NumReq);
    assign result_hs  = bus.unit_out_valid_i && bus.unit_out_ready_o;
    assign count_dec  = result_hs && (count_q != '0);

    assign bus.unit_valid_o = unit_valid;
    assign bus.unit_id_o    = issue_idx;
    assign bus.unit_data_o  = issue_data;
    assign busy_o           = (count_q != '0) || unit_valid;

    // Issue acceptance and result steering by returned tag.
    always_comb begin
        bus.req_ready_o      = '0;
        bus.resp_valid_o     = '0;
        bus.unit_out_ready_o = 1'b0;
        if (issue_hs) bus.req_ready_o[issue_idx] = 1'b1;
        if (route_ok) begin
            bus.resp_valid_o[bus.unit_out_id_i] = bus.unit_out_valid_i;
            bus.unit_out_ready_o                = bus.resp_ready_i[bus.unit_out_id_i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            if (issue_hs && !count_dec) begin
                count_q <= count_q + CntWidth'(1);
            end else if (!issue_hs && count_dec) begin
                count_q <= count_q - CntWidth'(1);
            end
            if (issue_hs) begin
                state_q  <= IDLE;
                rr_ptr_q <= next_ptr;
            end else if (unit_valid) begin
                state_q <= OFFER;
                grant_q <= issue_idx;
            end
        end
    end

endmodule

// File: tb/tb_fpnew_cast_arbiter.sv
// Directed bench for fpnew_cast_arbiter: combinational vector table plus
// multi-cycle sequences for fairness, stall, credit, flush and reset.
module tb_fpnew_cast_arbiter;
    import fpnew_pkg::*;

    typedef logic [7:0] pay_t;

    logic clk = 1'b0;
    bit   clk_run = 1'b1;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    fpnew_cast_arbiter_if #(.NumReq(2), .PayloadType(pay_t)) bus ();

    fpnew_cast_arbiter #(
        .NumReq      (2),
        .MaxInFlight (4),
        .PayloadType (pay_t)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .busy_o  (busy),
        .bus     (bus.master)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    typedef struct {
        logic [1:0] rv;
        logic       ur;
        logic       ov;
        logic       oid;
        logic [1:0] rrdy;
        logic       e_uv;
        logic       e_id;
        logic [1:0] e_rdy;
        logic [1:0] e_resp;
        logic       e_ordy;
        logic       e_busy;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] rv, input logic ur, input logic ov,
                         input logic oid, input logic [1:0] rrdy);
        bus.req_valid_i      = rv;
        bus.unit_ready_i     = ur;
        bus.unit_out_valid_i = ov;
        bus.unit_out_id_i    = oid;
        bus.resp_ready_i     = rrdy;
    endtask

    function automatic pay_t exp_data(input logic id);
        return id ? 8'hB1 : 8'hA0;
    endfunction

    initial begin
        // rv ur ov oid rrdy | uv id rdy resp ordy busy  (IDLE, rr_ptr=0, count=0)
        vecs[0] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
        vecs[2] = '{2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
        vecs[3] = '{2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};
        vecs[4] = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1};
        vecs[5] = '{2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 1'b1};
        vecs[6] = '{2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0};
        vecs[7] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0};
        vecs[8] = '{2'b01, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 2'b10, 1'b1, 1'b1};
        vecs[9] = '{2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};

        bus.req_data_i[0] = 8'hA0;
        bus.req_data_i[1] = 8'hB1;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);

        // Reset then idle
        next_cycle();
        check("rst_uv", 32'(bus.unit_valid_o), 32'd0);
        check("rst_count", 32'(dut.count_q), 32'd0);
        check("rst_rr", 32'(dut.rr_ptr_q), 32'd0);
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_uv", 32'(bus.unit_valid_o), 32'd0);
            check("idle_rdy", 32'(bus.req_ready_o), 32'd0);
            check("idle_resp", 32'(bus.resp_valid_o), 32'd0);
            next_cycle();
        end

        // Combinational vectors with the clock parked
        @(negedge clk);
        clk_run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rv, vecs[i].ur, vecs[i].ov, vecs[i].oid, vecs[i].rrdy);
            #1;
            check("vec_uv", 32'(bus.unit_valid_o), 32'(vecs[i].e_uv));
            if (vecs[i].e_uv) begin
                check("vec_id", 32'(bus.unit_id_o), 32'(vecs[i].e_id));
                check("vec_data", 32'(bus.unit_data_o), 32'(exp_data(vecs[i].e_id)));
            end
            check("vec_rdy", 32'(bus.req_ready_o), 32'(vecs[i].e_rdy));
            check("vec_resp", 32'(bus.resp_valid_o), 32'(vecs[i].e_resp));
            check("vec_ordy", 32'(bus.unit_out_ready_o), 32'(vecs[i].e_ordy));
            check("vec_busy", 32'(busy), 32'(vecs[i].e_busy));
        end
        drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
        #1;
        clk_run = 1'b1;
        next_cycle();
        check("vec_state_kept", 32'(dut.count_q), 32'd0);

        // Fairness: alternating grants until credits run out
        drive(2'b11, 1'b1, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fair_uv", 32'(bus.unit_valid_o), 32'd1);
            check("fair_id", 32'(bus.unit_id_o), 32'(i % 2));
            check("fair_rdy", 32'(bus.req_ready_o), (i % 2) ? 32'd2 : 32'd1);
            next_cycle();
        end
        #1;
        check("full_uv", 32'(bus.unit_valid_o), 32'd0);
        check("full_rdy", 32'(bus.req_ready_o), 32'd0);
        check("full_count", 32'(dut.count_q), 32'd4);
        check("full_busy", 32'(busy), 32'd1);

        // Result frees a credit, then issue and result in one cycle
        drive(2'b11, 1'b1, 1'b1, 1'b0, 2'b11);
        #1;
        check("free_uv", 32'(bus.unit_valid_o), 32'd0);
        check("free_resp", 32'(bus.resp_valid_o), 32'd1);
        check("free_ordy", 32'(bus.unit_out_ready_o), 32'd1);
        next_cycle();
        check("free_count", 32'(dut.count_q), 32'd3);
        #1;
        check("both_uv", 32'(bus.unit_valid_o), 32'd1);
        check("both_id", 32'(bus.unit_id_o), 32'd0);
        next_cycle();
        check("both_count", 32'(dut.count_q), 32'd3);
        check("both_rr", 32'(dut.rr_ptr_q), 32'd1);

        // Routing backpressure
        drive(2'b00, 1'b0, 1'b1, 1'b1, 2'b01);
        #1;
        check("bp_resp", 32'(bus.resp_valid_o), 32'd2);
        check("bp_ordy", 32'(bus.unit_out_ready_o), 32'd0);
        next_cycle();
        check("bp_count", 32'(dut.count_q), 32'd3);

        // Stall stability: lane 1 offered, lane 0 arrives meanwhile
        drive(2'b10, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) bus.req_valid_i = 2'b11;
            #1;
            check("stall_uv", 32'(bus.unit_valid_o), 32'd1);
            check("stall_id", 32'(bus.unit_id_o), 32'd1);
            check("stall_data", 32'(bus.unit_data_o), 32'hB1);
            check("stall_rdy", 32'(bus.req_ready_o), 32'd0);
            next_cycle();
            check("stall_state", 32'(dut.state_q), 32'(OFFER));
        end
        bus.unit_ready_i = 1'b1;
        #1;
        check("stall_acc_rdy", 32'(bus.req_ready_o), 32'd2);
        next_cycle();
        check("stall_count", 32'(dut.count_q), 32'd4);
        check("stall_rr", 32'(dut.rr_ptr_q), 32'd0);
        drive(2'b01, 1'b0, 1'b1, 1'b0, 2'b01);
        #1;
        check("stall_full_uv", 32'(bus.unit_valid_o), 32'd0);
        next_cycle();
        bus.unit_out_valid_i = 1'b0;
        #1;
        check("next_uv", 32'(bus.unit_valid_o), 32'd1);
        check("next_id", 32'(bus.unit_id_o), 32'd0);
        next_cycle();
        check("offer_state", 32'(dut.state_q), 32'(OFFER));
        check("offer_count", 32'(dut.count_q), 32'd3);

        // Flush while offering
        flush = 1'b1;
        bus.unit_ready_i = 1'b1;
        #1;
        check("flush_uv", 32'(bus.unit_valid_o), 32'd0);
        check("flush_rdy", 32'(bus.req_ready_o), 32'd0);
        next_cycle();
        flush = 1'b0;
        check("flush_count", 32'(dut.count_q), 32'd0);
        check("flush_state", 32'(dut.state_q), 32'(IDLE));
        check("flush_rr", 32'(dut.rr_ptr_q), 32'd0);
        drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
        #1;
        check("flush_busy0", 32'(busy), 32'd0);
        bus.req_valid_i = 2'b01;
        #1;
        check("flush_busy1", 32'(busy), 32'd1);
        bus.req_valid_i = 2'b00;
        next_cycle();

        // Result with no credits outstanding is routed but not counted
        drive(2'b00, 1'b0, 1'b1, 1'b0, 2'b01);
        #1;
        check("uf_resp", 32'(bus.resp_valid_o), 32'd1);
        check("uf_ordy", 32'(bus.unit_out_ready_o), 32'd1);
        next_cycle();
        check("uf_count", 32'(dut.count_q), 32'd0);

        // Reset in the middle of an offer
        drive(2'b01, 1'b1, 1'b0, 1'b0, 2'b00);
        next_cycle();
        check("pre_count", 32'(dut.count_q), 32'd1);
        check("pre_rr", 32'(dut.rr_ptr_q), 32'd1);
        drive(2'b10, 1'b0, 1'b0, 1'b0, 2'b00);
        next_cycle();
        check("pre_state", 32'(dut.state_q), 32'(OFFER));
        rst = 1'b1;
        #1;
        check("mid_rst_uv", 32'(bus.unit_valid_o), 32'd0);
        check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        check("mid_rst_count", 32'(dut.count_q), 32'd0);
        check("mid_rst_rr", 32'(dut.rr_ptr_q), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        next_cycle();
        rst = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpnew_cast_arbiter.md
FPNEW_CAST_ARBITER -- requirements
Module: fpnew_cast_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 2: number of requesters sharing one cast pipeline (range 2..8).
REQ-002 The block SHALL have parameter MaxInFlight, default 4: maximum number of operations outstanding in the pipeline (range 1..15).
REQ-003 The block SHALL have parameter type PayloadType, default logic: the opaque operand/control bundle forwarded to the cast unit.
REQ-004 The block SHALL have derived localparam IdWidth = max(1, clog2(NumReq)).
REQ-005 Clocking and reset SHALL be one clock, clk_i; reset rst_i is asynchronous and active-high.
REQ-006 Port clk_i SHALL be: input, 1 bit, clock.
REQ-007 Port rst_i SHALL be: input, 1 bit, asynchronous active-high reset.
REQ-008 Port req_valid_i SHALL be: input, NumReq bits, per-requester valid.
REQ-009 Port req_ready_o SHALL be: output, NumReq bits, per-requester accept.
REQ-010 Port req_data_i SHALL be: input, NumReq x PayloadType, per-requester payload.
REQ-011 Port unit_valid_o SHALL be: output, 1 bit, issue valid to the cast pipeline.
REQ-012 Port unit_ready_i SHALL be: input, 1 bit, cast pipeline input ready.
REQ-013 Port unit_data_o SHALL be: output, PayloadType, granted payload.
REQ-014 Port unit_id_o SHALL be: output, IdWidth bits, granted requester index, carried through the pipeline as tag.
REQ-015 Port unit_out_valid_i SHALL be: input, 1 bit, pipeline result valid.
REQ-016 Port unit_out_id_i SHALL be: input, IdWidth bits, returned tag.
REQ-017 Port unit_out_ready_o SHALL be: output, 1 bit, result accept.
REQ-018 Port resp_valid_o SHALL be: output, NumReq bits, per-requester result valid.
REQ-019 Port resp_ready_i SHALL be: input, NumReq bits, per-requester result ready.
REQ-020 Port flush_i SHALL be: input, 1 bit, synchronous kill of all in-flight state.
REQ-021 Port busy_o SHALL be: output, 1 bit, operation offered or in flight.

Function
REQ-022 The FSM SHALL have states IDLE and OFFER.
- IDLE: picks the grant combinationally.
- OFFER: holds the grant, id and payload stable until handshake.
REQ-023 In IDLE with credit available (count < MaxInFlight), grant SHALL go to the first valid requester at or after rr_ptr, searching cyclically; unit_valid_o SHALL assert in the same cycle.
REQ-024 An issue handshake (unit_valid_o & unit_ready_i) SHALL assert req_ready_o of the granted lane only, increment count, and set rr_ptr = grant+1 modulo NumReq; the FSM SHALL remain in or return to IDLE.
REQ-025 unit_valid_o without unit_ready_i SHALL move the FSM to OFFER and latch the grant index. In OFFER, the latched index SHALL drive unit_id_o/unit_data_o regardless of other requests, and the FSM SHALL return to IDLE on handshake.
REQ-026 Requesters SHALL keep req_valid_i and req_data_i stable until accepted; the block does not register payload.
REQ-027 When count == MaxInFlight, unit_valid_o SHALL be 0 and all req_ready_o SHALL be 0 (no issue while the credits are exhausted).
REQ-028 Result routing SHALL be combinational with zero latency:
- resp_valid_o[unit_out_id_i] = unit_out_valid_i, all other bits 0.
- unit_out_ready_o = resp_ready_i[unit_out_id_i].
REQ-029 A result handshake SHALL decrement count; a simultaneous issue and result SHALL leave count unchanged; a result with count == 0 SHALL be ignored for counting (no underflow).
REQ-030 flush_i SHALL take priority over all events in that cycle:
- count becomes 0 and the FSM becomes IDLE;
- unit_valid_o and req_ready_o are forced to 0 that cycle;
- rr_ptr is unchanged.
REQ-031 busy_o SHALL be (count != 0) | unit_valid_o.
REQ-032 The issue path SHALL add zero cycles of latency (request to unit_valid_o combinational); total latency equals the pipeline depth.

Reset
REQ-033 While rst_i is high, asynchronously, the block SHALL force: FSM=IDLE, rr_ptr=0, count=0, latched grant=0.
REQ-034 With no requests pending after reset, the block SHALL drive unit_valid_o=0, req_ready_o=0, busy_o=0 and resp_valid_o=0 (resp_valid_o is 0 given unit_out_valid_i=0).
REQ-035 Reset asserted mid-offer SHALL drop unit_valid_o immediately; outstanding results arriving after reset SHALL be routed but not counted (REQ-029).

Structure
REQ-036 Any shared constants (maximum NumReq) SHALL live in fpnew_pkg; no new typedefs are required.
REQ-037 The block SHALL contain one natural sub-module, fpnew_rr_arb_tree (or an equivalent local round-robin picker), for the cyclic priority search; counter and FSM SHALL stay inline.

Verification
REQ-038 Reset then idle: no requests -> busy_o=0, unit_valid_o=0 for 10 cycles.
REQ-039 Fairness: NumReq=2, both lanes valid continuously, unit_ready_i=1, no results returned, MaxInFlight=4 -> ids issued 0,1,0,1, then unit_valid_o=0 with count=4.
REQ-040 Stall stability: lane 1 valid, unit_ready_i=0 for 3 cycles while lane 0 raises valid -> unit_id_o stays 1 for all 3 cycles; on ready, lane 1 accepted, next grant goes to 0.
REQ-041 Simultaneous events: count=4, result id=0 with resp_ready_i[0]=1 in the same cycle that credit frees -> count=3 next cycle, then an issue plus a result in one cycle -> count stays 3.
REQ-042 Flush: count=3 with OFFER pending; pulse flush_i -> next cycle count=0, FSM=IDLE, busy_o equal to the new request state only.
REQ-043 Routing backpressure: result id=1, resp_ready_i=2'b01 -> resp_valid_o=2'b10, unit_out_ready_o=0, count unchanged.
